// File: rtl/addsub_pkg.sv
// Shared definitions for the serial adder/subtractor: mode encoding, FSM states and
// a constant clog2 used to size the chunk index.
package addsub_pkg;

    localparam logic ADD = 1'b0;
    localparam logic SUB = 1'b1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_e;

    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((64'(1) << i) < 64'(n)) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/addsub_chunk.sv
// Combinational CHUNK-bit ripple adder; also exposes the carry into the top bit so
// the caller can form signed overflow.
module addsub_chunk #(
    parameter int unsigned CHUNK = 2
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] s,
    output logic             cout,
    output logic             c_msb
);

    logic [CHUNK:0] c;

    always_comb begin
        c    = '0;
        s    = '0;
        c[0] = cin;
        for (int i = 0; i < CHUNK; i++) begin
            s[i]   = a[i] ^ b[i] ^ c[i];
            c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
        end
    end

    assign cout  = c[CHUNK];
    assign c_msb = c[CHUNK-1];

endmodule

// File: rtl/addsub_serial.sv
// Multi-cycle two's-complement adder/subtractor: resolves CHUNK bits per cycle,
// LSB chunk first, through a registered carry, with valid/ready on both sides.
module addsub_serial
    import addsub_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CHUNK = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             ovf,
    output logic             zero,
    output logic             neg
);

    localparam int unsigned NCHUNK = WIDTH / CHUNK;
    localparam int unsigned IDX_W  = (clog2(NCHUNK) > 0) ? clog2(NCHUNK) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCHUNK - 1);

    if ((WIDTH % CHUNK) != 0 || WIDTH < 2 || CHUNK < 1) begin : g_bad_cfg
        $fatal(1, "addsub_serial: WIDTH must be >= 2 and a multiple of CHUNK");
    end

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, b_q, s_q;
    logic             carry_q, cout_q, ovf_q;
    logic [IDX_W-1:0] idx_q;

    logic [CHUNK-1:0] ch_a, ch_b, ch_s;
    logic             ch_cout, ch_cmsb;
    logic             last;

    assign ch_a = a_q[idx_q*CHUNK +: CHUNK];
    assign ch_b = b_q[idx_q*CHUNK +: CHUNK];
    assign last = (idx_q == LAST_IDX);

    addsub_chunk #(
        .CHUNK(CHUNK)
    ) u_chunk (
        .a    (ch_a),
        .b    (ch_b),
        .cin  (carry_q),
        .s    (ch_s),
        .cout (ch_cout),
        .c_msb(ch_cmsb)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid)  state_d = RUN;
            RUN:     if (last)      state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q     <= '0;
            b_q     <= '0;
            s_q     <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            idx_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        // Subtraction is A + ~B + 1: invert B here, the +1 enters as carry-in.
                        a_q     <= a;
                        b_q     <= b ^ {WIDTH{sub == SUB}};
                        carry_q <= sub;
                        idx_q   <= '0;
                    end
                end
                RUN: begin
                    s_q[idx_q*CHUNK +: CHUNK] <= ch_s;
                    carry_q                   <= ch_cout;
                    idx_q                     <= idx_q + IDX_W'(1);
                    if (last) begin
                        cout_q <= ch_cout;
                        ovf_q  <= ch_cout ^ ch_cmsb;
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign s         = s_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;
    // Gated by out_valid so both flags read 0 out of reset rather than reflecting s == 0.
    assign zero      = out_valid & ~|s_q;
    assign neg       = out_valid & s_q[WIDTH-1];

endmodule

// File: tb/tb_addsub_serial.sv
// Scoreboard bench for addsub_serial: directed 8/2 vectors plus a random sweep over
// 4/1, 16/4 and 8/8 instances checked against a behavioural reference.
module tb_addsub_serial;

    typedef struct {
        logic [15:0] s;
        logic        cout;
        logic        ovf;
        logic        zero;
        logic        neg;
        int          acc;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    // Main 8/2 instance
    logic       rst_n, iv8, sub8, or8;
    logic [7:0] a8, b8;
    logic       ir8, ov8, cout8, ovf8, zero8, neg8;
    logic [7:0] s8;

    addsub_serial #(.WIDTH(8), .CHUNK(2)) u_main (
        .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8), .sub(sub8),
        .out_valid(ov8), .out_ready(or8), .s(s8), .cout(cout8), .ovf(ovf8), .zero(zero8),
        .neg(neg8)
    );

    // Sweep instances share stimulus
    logic        rst_sw, iv_sw, sub_sw, or_sw;
    logic [15:0] a_sw, b_sw;
    logic        ir4, ov4, c4, o4, z4, n4;
    logic [3:0]  s4;
    logic        ir16, ov16, c16, o16, z16, n16;
    logic [15:0] s16;
    logic        ir88, ov88, c88, o88, z88, n88;
    logic [7:0]  s88;

    addsub_serial #(.WIDTH(4), .CHUNK(1)) u_w4 (
        .clk(clk), .rst_n(rst_sw), .in_valid(iv_sw), .in_ready(ir4), .a(a_sw[3:0]),
        .b(b_sw[3:0]), .sub(sub_sw), .out_valid(ov4), .out_ready(or_sw), .s(s4), .cout(c4),
        .ovf(o4), .zero(z4), .neg(n4)
    );
    addsub_serial #(.WIDTH(16), .CHUNK(4)) u_w16 (
        .clk(clk), .rst_n(rst_sw), .in_valid(iv_sw), .in_ready(ir16), .a(a_sw), .b(b_sw),
        .sub(sub_sw), .out_valid(ov16), .out_ready(or_sw), .s(s16), .cout(c16), .ovf(o16),
        .zero(z16), .neg(n16)
    );
    addsub_serial #(.WIDTH(8), .CHUNK(8)) u_w88 (
        .clk(clk), .rst_n(rst_sw), .in_valid(iv_sw), .in_ready(ir88), .a(a_sw[7:0]),
        .b(b_sw[7:0]), .sub(sub_sw), .out_valid(ov88), .out_ready(or_sw), .s(s88), .cout(c88),
        .ovf(o88), .zero(z88), .neg(n88)
    );

    exp_t q8[$], q4[$], q16[$], q88[$];
    logic pv8 = 1'b0, pv4 = 1'b0, pv16 = 1'b0, pv88 = 1'b0;

    task automatic chk(input string name, input logic [15:0] got, input logic [15:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%h want=%h (cycle %0d)", name, got, want, cyc);
        end
    endtask

    // Reference: modulo-2^w add of A and (B or ~B) with carry-in, ovf from operand signs.
    function automatic exp_t model(input logic [15:0] a, input logic [15:0] b, input logic sb,
                                   input int w);
        exp_t        e;
        logic [15:0] mask, aa, bb;
        logic [16:0] full;
        mask   = 16'hFFFF >> (16 - w);
        aa     = a & mask;
        bb     = (sb ? ~b : b) & mask;
        full   = {1'b0, aa} + {1'b0, bb} + 17'(sb);
        e.s    = full[15:0] & mask;
        e.cout = full[w];
        e.ovf  = (aa[w-1] == bb[w-1]) && (e.s[w-1] != aa[w-1]);
        e.zero = (e.s == 16'd0);
        e.neg  = e.s[w-1];
        e.acc  = 0;
        return e;
    endfunction

    task automatic check_out(input string tag, input exp_t e, input logic rise, input int n,
                             input logic [15:0] s_, input logic c_, input logic o_,
                             input logic z_, input logic n_, input logic ir);
        chk({tag, ".s"}, s_, e.s);
        chk({tag, ".cout"}, 16'(c_), 16'(e.cout));
        chk({tag, ".ovf"}, 16'(o_), 16'(e.ovf));
        chk({tag, ".zero"}, 16'(z_), 16'(e.zero));
        chk({tag, ".neg"}, 16'(n_), 16'(e.neg));
        chk({tag, ".in_ready_busy"}, 16'(ir), 16'd0);
        if (rise) chk({tag, ".latency"}, 16'(cyc - e.acc), 16'(n));
    endtask

    task automatic spurious(input string tag);
        checks++;
        errors++;
        $display("FAIL %s.spurious out_valid=1 expected none", tag);
    endtask

    // Monitors: compare the queue head whenever a result is presented
    always @(negedge clk) begin
        if (ov8) begin
            if (q8.size() == 0) spurious("main");
            else begin
                check_out("main", q8[0], !pv8, 4, 16'(s8), cout8, ovf8, zero8, neg8, ir8);
                if (or8) void'(q8.pop_front());
            end
        end
        pv8 = ov8;
    end
    always @(negedge clk) begin
        if (ov4) begin
            if (q4.size() == 0) spurious("w4");
            else begin
                check_out("w4", q4[0], !pv4, 4, 16'(s4), c4, o4, z4, n4, ir4);
                if (or_sw) void'(q4.pop_front());
            end
        end
        pv4 = ov4;
    end
    always @(negedge clk) begin
        if (ov16) begin
            if (q16.size() == 0) spurious("w16");
            else begin
                check_out("w16", q16[0], !pv16, 4, s16, c16, o16, z16, n16, ir16);
                if (or_sw) void'(q16.pop_front());
            end
        end
        pv16 = ov16;
    end
    always @(negedge clk) begin
        if (ov88) begin
            if (q88.size() == 0) spurious("w88");
            else begin
                check_out("w88", q88[0], !pv88, 1, 16'(s88), c88, o88, z88, n88, ir88);
                if (or_sw) void'(q88.pop_front());
            end
        end
        pv88 = ov88;
    end

    task automatic send8(input logic [7:0] a, input logic [7:0] b, input logic sb,
                         input logic [7:0] es, input logic ec, input logic eo,
                         input logic ez, input logic en);
        exp_t e;
        bit   ok;
        @(negedge clk);
        a8 = a; b8 = b; sub8 = sb; iv8 = 1'b1;
        ok = 0;
        for (int t = 0; t < 40 && !ok; t++) begin
            if (ir8) begin
                @(posedge clk);
                #1;
                ok = 1;
            end else @(negedge clk);
        end
        iv8 = 1'b0;
        if (!ok) begin
            checks++; errors++;
            $display("FAIL main.accept in_ready=0 want=1 (timeout)");
        end else begin
            e.s = 16'(es); e.cout = ec; e.ovf = eo; e.zero = ez; e.neg = en; e.acc = cyc;
            q8.push_back(e);
        end
    endtask

    task automatic drain8();
        for (int t = 0; t < 60 && q8.size() != 0; t++) @(negedge clk);
        chk("main.drain", 16'(q8.size()), 16'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; iv8 = 1'b0; a8 = '0; b8 = '0; sub8 = 1'b0; or8 = 1'b1;
        rst_sw = 1'b0; iv_sw = 1'b0; a_sw = '0; b_sw = '0; sub_sw = 1'b0; or_sw = 1'b1;
        #12;
        chk("rst.in_ready", 16'(ir8), 16'd1);
        chk("rst.out_valid", 16'(ov8), 16'd0);
        chk("rst.s", 16'(s8), 16'd0);
        chk("rst.flags", 16'({cout8, ovf8, zero8, neg8}), 16'd0);
        @(negedge clk);
        rst_n = 1'b1; rst_sw = 1'b1;

        send8(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, 1'b0, 1'b1); drain8();
        send8(8'h05, 8'h07, 1'b1, 8'hFE, 1'b0, 1'b0, 1'b0, 1'b1); drain8();
        send8(8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1, 1'b0, 1'b0); drain8();
        send8(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0); drain8();
        send8(8'h3C, 8'h3C, 1'b1, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0); drain8();

        // Backpressure: result held for several DONE cycles while the monitor re-checks it
        or8 = 1'b0;
        send8(8'hA5, 8'h5A, 1'b0, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b1);
        repeat (9) @(negedge clk);
        or8 = 1'b1;
        drain8();

        // Inputs wiggle during RUN; result must reflect the accepted operands
        send8(8'h21, 8'h43, 1'b1, 8'hDE, 1'b0, 1'b0, 1'b0, 1'b1);
        @(negedge clk); a8 = 8'hFF; b8 = 8'hFF; sub8 = 1'b0; iv8 = 1'b1;
        @(negedge clk); a8 = 8'h00; b8 = 8'h80; iv8 = 1'b0;
        @(negedge clk); a8 = 8'h11; iv8 = 1'b1;
        @(negedge clk); iv8 = 1'b0;
        drain8();

        // Abort in the second RUN cycle
        send8(8'h55, 8'h11, 1'b0, 8'h66, 1'b0, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        q8.delete();
        #1;
        chk("abort.out_valid", 16'(ov8), 16'd0);
        chk("abort.in_ready", 16'(ir8), 16'd1);
        chk("abort.s", 16'(s8), 16'd0);
        chk("abort.flags", 16'({cout8, ovf8, zero8, neg8}), 16'd0);
        @(negedge clk);
        rst_n = 1'b1;
        send8(8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0, 1'b0, 1'b0); drain8();

        // Random sweep over the other configurations
        for (int v = 0; v < 1200; v++) begin
            exp_t e;
            @(negedge clk);
            chk("sweep.in_ready", 16'({ir4, ir16, ir88}), 16'h7);
            a_sw = 16'($urandom); b_sw = 16'($urandom); sub_sw = 1'($urandom);
            iv_sw = 1'b1;
            @(posedge clk);
            #1;
            iv_sw = 1'b0;
            e = model(a_sw, b_sw, sub_sw, 4);  e.acc = cyc; q4.push_back(e);
            e = model(a_sw, b_sw, sub_sw, 16); e.acc = cyc; q16.push_back(e);
            e = model(a_sw, b_sw, sub_sw, 8);  e.acc = cyc; q88.push_back(e);
            repeat (6) @(negedge clk);
        end
        repeat (4) @(negedge clk);
        chk("sweep.drain", 16'(q4.size() + q16.size() + q88.size()), 16'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
